// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: one radix-2 step per cycle, with abort
// support and the RISC-V divide-by-zero / signed-overflow results.
module muldiv_unit #(
  parameter  int XLEN       = 32,
  parameter  int REG_ADDR_W = 5,
  localparam int CNT_W      = $clog2(XLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       rs1_rdata,
  input  logic [XLEN-1:0]       rs2_rdata,
  input  logic [REG_ADDR_W-1:0] rd_waddr,
  input  logic                  abort_i,
  output logic                  hold_o,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_waddr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_e                  state_q;
  logic [2:0]              op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [REG_ADDR_W-1:0]   rd_out_q;
  logic                    a_neg_q;
  logic                    neg_q;
  logic [XLEN-1:0]         opnd_q;
  logic [XLEN-1:0]         result_q;
  logic [2*XLEN-1:0]       acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    valid_q;

  logic                    is_div_s;
  logic                    a_neg_s;
  logic                    b_neg_s;
  logic [XLEN-1:0]         a_abs_s;
  logic [XLEN-1:0]         b_abs_s;
  logic                    special_s;
  logic [XLEN-1:0]         special_res_s;
  logic [XLEN:0]           mul_sum_s;
  logic [XLEN:0]           div_part_s;
  logic [XLEN:0]           div_diff_s;
  logic [2*XLEN-1:0]       acc_d;
  logic [2*XLEN-1:0]       prod_s;
  logic [XLEN-1:0]         quot_s;
  logic [XLEN-1:0]         rem_s;
  logic [XLEN-1:0]         fix_res_d;

  // Dispatch decode: operand signs, magnitudes and the early-out cases
  always_comb begin
    is_div_s = op_i[2];
    a_neg_s  = rs1_rdata[XLEN-1] & (is_div_s ? ~op_i[0] : (op_i[1:0] != 2'b11));
    b_neg_s  = rs2_rdata[XLEN-1] & (is_div_s ? ~op_i[0] : ~op_i[1]);
    a_abs_s  = a_neg_s ? -rs1_rdata : rs1_rdata;
    b_abs_s  = b_neg_s ? -rs2_rdata : rs2_rdata;
    if (is_div_s && (rs2_rdata == '0)) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? rs1_rdata : '1;
    end else if (is_div_s && !op_i[0] && (rs1_rdata == MIN_INT) && (rs2_rdata == '1)) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? '0 : rs1_rdata;
    end else begin
      special_s     = 1'b0;
      special_res_s = '0;
    end
  end

  // Iteration step: acc holds {high product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_part_s = acc_q[2*XLEN-1:XLEN-1];
    div_diff_s = div_part_s - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff_s[XLEN]) begin
        acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {div_part_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod_s = neg_q ? -acc_q : acc_q;
    quot_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_res_d = op_q[1] ? rem_s : quot_s;
    end else begin
      fix_res_d = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with the datapath registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 3'b000;
      rd_q     <= '0;
      rd_out_q <= '0;
      a_neg_q  <= 1'b0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            op_q    <= op_i;
            rd_q    <= rd_waddr;
            a_neg_q <= a_neg_s;
            neg_q   <= a_neg_s ^ b_neg_s;
            cnt_q   <= '0;
            if (special_s) begin
              result_q <= special_res_s;
              rd_out_q <= rd_waddr;
              valid_q  <= 1'b1;
              state_q  <= DONE;
            end else begin
              opnd_q  <= is_div_s ? b_abs_s : a_abs_s;
              acc_q   <= {{XLEN{1'b0}}, (is_div_s ? a_abs_s : b_abs_s)};
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res_d;
            rd_out_q <= rd_q;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hold_o         = ((state_q == IDLE) && start_i) || (state_q == CALC) || (state_q == FIX);
  assign busy_o         = (state_q != IDLE);
  assign result_valid_o = valid_q & ~abort_i;
  assign result_o       = result_q;
  assign rd_waddr_o     = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written abort/reset
// sequences, and randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;
  logic [4:0]  rd_waddr;
  logic        abort_i;
  logic        hold_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_waddr_o;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .rs1_rdata      (rs1_rdata),
    .rs2_rdata      (rs2_rdata),
    .rd_waddr       (rd_waddr),
    .abort_i        (abort_i),
    .hold_o         (hold_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .rd_waddr_o     (rd_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'b000: begin p = 64'(ua * ub); return p[31:0];  end
      3'b001: begin p = 64'(sa * sb); return p[63:32]; end
      3'b010: begin p = 64'(sa * ub); return p[63:32]; end
      3'b011: begin p = 64'(ua * ub); return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  // Start an op at the next negedge (cycle 0); optionally re-pulse start_i at cycle glitch_at
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int glitch_at,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output bit hold_ok);
    @(negedge clk);
    op_i = op; rs1_rdata = a; rs2_rdata = b; rd_waddr = rd; start_i = 1'b1;
    #1;
    hold_ok = (hold_o === 1'b1);
    lat = -1; res = 32'h0; rdo = 5'h0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == glitch_at) begin
        start_i = 1'b1; op_i = 3'b011; rd_waddr = ~rd;
      end else begin
        start_i = 1'b0;
      end
      rs1_rdata = $urandom; rs2_rdata = $urandom;
      #1;
      if (result_valid_o === 1'b1) begin
        lat = k; res = result_o; rdo = rd_waddr_o;
        if (hold_o !== 1'b0) hold_ok = 1'b0;
        break;
      end
      if (hold_o !== 1'b1) hold_ok = 1'b0;
    end
    start_i = 1'b0;
  endtask

  vec_t        vecs[16];
  logic [31:0] res;
  logic [4:0]  rdo;
  int          lat;
  bit          hok;
  bit          saw_valid;
  logic [2:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [4:0]  rrd;
  int          rlat;

  initial begin
    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34};
    vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34};
    vecs[7]  = '{3'b101, 32'd20,         32'd3,          32'd6,         34};
    vecs[8]  = '{3'b111, 32'd20,         32'd3,          32'd2,         34};
    vecs[9]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[10] = '{3'b110, 32'd5,          32'd0,          32'd5,         1};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[13] = '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
    vecs[14] = '{3'b111, 32'd5,          32'd0,          32'd5,         1};
    vecs[15] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};

    rst = 1'b1; start_i = 1'b0; op_i = 3'b000; rs1_rdata = 32'h0; rs2_rdata = 32'h0;
    rd_waddr = 5'h0; abort_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",  32'(busy_o), 32'h0);
    check("rst_valid", 32'(result_valid_o), 32'h0);
    check("rst_hold",  32'(hold_o), 32'h0);
    check("rst_result", result_o, 32'h0);
    check("rst_rd",    32'(rd_waddr_o), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 0, res, rdo, lat, hok);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_rd", i), 32'(rdo), 32'(i + 1));
      check($sformatf("vec%0d_hold", i), 32'(hok), 32'h1);
    end

    // Abort a DIVU in CALC at cycle 10, then start a MUL at cycle 12
    @(negedge clk);
    op_i = 3'b101; rs1_rdata = 32'd100; rs2_rdata = 32'd7; rd_waddr = 5'd4; start_i = 1'b1;
    saw_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      abort_i = (k == 10);
      #1;
      if (result_valid_o === 1'b1) saw_valid = 1'b1;
    end
    check("abort_calc_busy", 32'(busy_o), 32'h0);
    check("abort_calc_no_valid", 32'(saw_valid), 32'h0);
    run_op(3'b000, 32'd3, 32'd4, 5'd6, 0, res, rdo, lat, hok);
    check("after_abort_result", res, 32'd12);
    check("after_abort_latency", 32'(lat), 32'd34);

    // Start pulse while busy must be ignored
    run_op(3'b000, 32'd6, 32'd7, 5'd3, 5, res, rdo, lat, hok);
    check("busy_start_result", res, 32'd42);
    check("busy_start_latency", 32'(lat), 32'd34);
    check("busy_start_rd", 32'(rdo), 32'd3);

    // Abort in DONE suppresses the strobe
    @(negedge clk);
    op_i = 3'b100; rs1_rdata = 32'd5; rs2_rdata = 32'd0; rd_waddr = 5'd9; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b1;
    #1;
    check("abort_done_valid", 32'(result_valid_o), 32'h0);
    @(negedge clk);
    abort_i = 1'b0;
    #1;
    check("abort_done_busy", 32'(busy_o), 32'h0);

    // Abort together with start in IDLE drops the start
    @(negedge clk);
    op_i = 3'b000; rs1_rdata = 32'd2; rs2_rdata = 32'd2; start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    #1;
    check("abort_idle_busy", 32'(busy_o), 32'h0);

    // Synchronous reset at cycle 15 of a MUL
    @(negedge clk);
    op_i = 3'b000; rs1_rdata = 32'd9; rs2_rdata = 32'd9; rd_waddr = 5'd7; start_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midop_rst_busy",   32'(busy_o), 32'h0);
    check("midop_rst_valid",  32'(result_valid_o), 32'h0);
    check("midop_rst_result", result_o, 32'h0);
    check("midop_rst_rd",     32'(rd_waddr_o), 32'h0);

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      rrd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      rlat = (rop[2] && (rb == 32'h0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)))
             ? 1 : 34;
      run_op(rop, ra, rb, rrd, 0, res, rdo, lat, hok);
      check($sformatf("rand%0d_op%0d_result", n, rop), res, ref_model(rop, ra, rb));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(rlat));
      check($sformatf("rand%0d_rd", n), 32'(rdo), 32'(rrd));
      check($sformatf("rand%0d_hold", n), 32'(hok), 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
